stage_ra_pipe: RTL and testbench

STAGE_RA_PIPE -- requirements
Module: stage_ra_pipe

---
 rtl/stage_ra_pipe.sv | 78 +++++++
 tb/tb_stage_ra_pipe.sv | 135 +++++++++++++
 2 files changed

// File: rtl/stage_ra_pipe.sv
// stage_ra_pipe: 2-entry in-order main+skid buffer between the RA and RO stages.
// Outputs come straight from the head register; in_ready depends only on occupancy.
module stage_ra_pipe #(
    parameter int DATA_W    = 12,
    parameter int SET_W     = 4,
    parameter int FLAG_W    = 4,
    parameter int ADDR_W    = 4,
    parameter int ADDR_LSB  = 4,
    parameter int RESET_SET = 0,
    parameter int STALL_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               clr_stats,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  pc_in,
    input  logic [DATA_W-1:0]  instr_in,
    input  logic [DATA_W-1:0]  result_in,
    input  logic [SET_W-1:0]   instr_set_in,
    input  logic [FLAG_W-1:0]  flags_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  pc_out,
    output logic [DATA_W-1:0]  instr_out,
    output logic [DATA_W-1:0]  result_out,
    output logic [SET_W-1:0]   instr_set_out,
    output logic [FLAG_W-1:0]  flags_out,
    output logic [ADDR_W-1:0]  reg_waddr_out,
    output logic [1:0]         occupancy,
    output logic [STALL_W-1:0] stall_cnt
);
    localparam int W = 3*DATA_W + SET_W + FLAG_W + ADDR_W;

    logic [W-1:0] head, skid, din, rst_val;
    logic [1:0]   occ;
    logic         push, pop;

    always_comb begin
        push    = in_valid && occ != 2'd2 && !flush;
        pop     = occ != 2'd0 && out_ready && !flush;
        din     = {pc_in, instr_in, result_in, instr_set_in, flags_in,
                   instr_in[ADDR_LSB+ADDR_W-1:ADDR_LSB]};
        rst_val = W'(SET_W'(RESET_SET)) << (FLAG_W + ADDR_W);
    end

    assign in_ready  = occ != 2'd2;
    assign out_valid = occ != 2'd0;
    assign occupancy = occ;
    assign {pc_out, instr_out, result_out, instr_set_out, flags_out, reg_waddr_out} = head;

    // Head reloads from input when it is (or is becoming) free, else from skid on a pop at full.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= 2'd0;
            head <= rst_val;
            skid <= '0;
        end else if (flush) begin
            occ <= 2'd0;
        end else begin
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (push && (occ == 2'd0 || pop))
                head <= din;
            else if (pop && occ == 2'd2)
                head <= skid;
            if (push && occ == 2'd1 && !pop)
                skid <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_stats)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && !flush && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_stage_ra_pipe.sv
// tb_stage_ra_pipe: table-driven vectors plus a queue scoreboard for stage_ra_pipe.
// The model tracks occupancy, head payload and stall count independently of the DUT.
module tb_stage_ra_pipe;
    logic        clk = 0, rst = 0, flush = 0, clr_stats = 0, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid;
    logic [11:0] pc_in = 0, instr_in = 0, result_in = 0, pc_out, instr_out, result_out;
    logic [3:0]  instr_set_in = 0, flags_in = 0, instr_set_out, flags_out, reg_waddr_out, stall_cnt;
    logic [1:0]  occupancy;

    stage_ra_pipe #(.RESET_SET(3), .STALL_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .instr_in(instr_in), .result_in(result_in),
        .instr_set_in(instr_set_in), .flags_in(flags_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .instr_out(instr_out), .result_out(result_out),
        .instr_set_out(instr_set_out), .flags_out(flags_out),
        .reg_waddr_out(reg_waddr_out), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] pc, instr, res;
        logic [3:0]  set, flags, waddr;
    } beat_t;

    typedef struct {
        logic        rst, iv;
        logic [11:0] pc, instr;
        logic        ordy, fl;
        logic [1:0]  occ;
        logic        valid, ready;
        logic [11:0] pc_exp;
    } vec_t;

    beat_t q[$];
    beat_t held;
    int    stall_m = 0;
    int    n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cyc(input logic r, input logic iv, input logic [11:0] pc, input logic [11:0] instr,
                       input logic ordy, input logic fl, input logic clr);
        beat_t b;
        logic  do_push, do_pop;
        b = '{pc: pc, instr: instr, res: pc ^ 12'hABC, set: pc[3:0], flags: ~pc[3:0], waddr: instr[7:4]};
        rst = r; in_valid = iv; pc_in = pc; instr_in = instr; result_in = b.res;
        instr_set_in = b.set; flags_in = b.flags; out_ready = ordy; flush = fl; clr_stats = clr;
        if (r) begin
            q.delete();
            held = '{pc: 0, instr: 0, res: 0, set: 4'd3, flags: 0, waddr: 0};
            stall_m = 0;
        end else begin
            if (clr) stall_m = 0;
            else if (q.size() != 0 && !ordy && !fl && stall_m < 15) stall_m++;
            if (fl) q.delete();
            else begin
                do_push = iv && q.size() < 2;
                do_pop  = q.size() != 0 && ordy;
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back(b);
            end
            if (q.size() != 0) held = q[0];
        end
        @(posedge clk);
        #1;
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("pc_out", 32'(pc_out), 32'(held.pc));
        chk("instr_out", 32'(instr_out), 32'(held.instr));
        chk("result_out", 32'(result_out), 32'(held.res));
        chk("instr_set_out", 32'(instr_set_out), 32'(held.set));
        chk("flags_out", 32'(flags_out), 32'(held.flags));
        chk("reg_waddr_out", 32'(reg_waddr_out), 32'(held.waddr));
        chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
    endtask

    vec_t tbl[15];

    initial begin
        tbl = '{
            '{1, 0, 12'h000, 12'h000, 0, 0, 2'd0, 0, 1, 12'h000},
            '{0, 1, 12'h010, 12'h0A5, 1, 0, 2'd1, 1, 1, 12'h010},
            '{0, 0, 12'h000, 12'h000, 1, 0, 2'd0, 0, 1, 12'h010},
            '{0, 1, 12'h001, 12'h013, 0, 0, 2'd1, 1, 1, 12'h001},
            '{0, 1, 12'h002, 12'h023, 0, 0, 2'd2, 1, 0, 12'h001},
            '{0, 1, 12'h003, 12'h033, 0, 0, 2'd2, 1, 0, 12'h001},
            '{0, 0, 12'h000, 12'h000, 1, 0, 2'd1, 1, 1, 12'h002},
            '{0, 0, 12'h000, 12'h000, 1, 0, 2'd0, 0, 1, 12'h002},
            '{0, 1, 12'h004, 12'h043, 0, 0, 2'd1, 1, 1, 12'h004},
            '{0, 1, 12'h005, 12'h053, 1, 0, 2'd1, 1, 1, 12'h005},
            '{0, 1, 12'h006, 12'h063, 0, 0, 2'd2, 1, 0, 12'h005},
            '{0, 1, 12'h007, 12'h073, 0, 1, 2'd0, 0, 1, 12'h005},
            '{0, 1, 12'h008, 12'h083, 0, 0, 2'd1, 1, 1, 12'h008},
            '{0, 1, 12'h009, 12'h093, 0, 0, 2'd2, 1, 0, 12'h008},
            '{1, 1, 12'h00A, 12'h0A3, 0, 0, 2'd0, 0, 1, 12'h000}
        };
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].rst, tbl[i].iv, tbl[i].pc, tbl[i].instr, tbl[i].ordy, tbl[i].fl, 0);
            chk($sformatf("tbl[%0d].occupancy", i), 32'(occupancy), 32'(tbl[i].occ));
            chk($sformatf("tbl[%0d].out_valid", i), 32'(out_valid), 32'(tbl[i].valid));
            chk($sformatf("tbl[%0d].in_ready", i), 32'(in_ready), 32'(tbl[i].ready));
            chk($sformatf("tbl[%0d].pc_out", i), 32'(pc_out), 32'(tbl[i].pc_exp));
            if (i == 1) chk("tbl[1].reg_waddr_out", 32'(reg_waddr_out), 32'hA);
            if (i == 14) chk("tbl[14].instr_set_out", 32'(instr_set_out), 32'd3);
        end
        // Stall saturation, flush leaves the count alone, clr_stats beats an increment.
        cyc(0, 1, 12'h0B0, 12'h0B1, 0, 0, 1);
        for (int i = 0; i < 20; i++) cyc(0, 0, 12'h000, 12'h000, 0, 0, 0);
        chk("stall_sat", 32'(stall_cnt), 32'd15);
        cyc(0, 0, 12'h000, 12'h000, 0, 0, 1);
        chk("stall_clr", 32'(stall_cnt), 32'd0);
        cyc(0, 0, 12'h000, 12'h000, 0, 0, 0);
        cyc(0, 0, 12'h000, 12'h000, 0, 1, 0);
        chk("stall_after_flush", 32'(stall_cnt), 32'd1);
        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            automatic logic [11:0] p = 12'($urandom);
            cyc($urandom_range(0, 49) == 0, 1'($urandom), p, 12'($urandom),
                $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
